// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: matrix geometry, MemoryBlock port widths,
// result-area base address and the result reader state encoding.
package coproc_pkg;

    localparam int unsigned N_ELEM           = 25;
    localparam int unsigned ELEM_W           = 8;
    localparam int unsigned ELEM_IDX_W       = 5;
    localparam int unsigned MEM_ADDR_W       = 7;
    localparam int unsigned MEM_DATA_W       = 16;
    // Result write-back pre-increments its address, so element 0 lives at 1.
    localparam int unsigned RESULT_BASE_ADDR = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } rd_state_t;

endpackage

// File: rtl/matrix_result_reader_if.sv
// Element stream from the result reader toward the host/display side.
//   elem_valid : element on elem_data is valid
//   elem_ready : consumer accepts the element
//   elem_data  : signed 8-bit element
//   elem_index : index k of the presented element
//   elem_last  : high with elem_valid on the final element
// master = producer (reader), slave = consumer.
interface matrix_result_reader_if;
    import coproc_pkg::*;

    logic                  elem_valid;
    logic                  elem_ready;
    logic [ELEM_W-1:0]     elem_data;
    logic [ELEM_IDX_W-1:0] elem_index;
    logic                  elem_last;

    modport master (
        output elem_valid,
        output elem_data,
        output elem_index,
        output elem_last,
        input  elem_ready
    );

    modport slave (
        input  elem_valid,
        input  elem_data,
        input  elem_index,
        input  elem_last,
        output elem_ready
    );

endinterface

// File: rtl/matrix_result_reader.sv
// Drains a finished result matrix from MemoryBlock. Words {8'b0, r[7:0]} are
// fetched sequentially from BASE_ADDR, the low byte of each is presented on a
// valid/ready element stream and also packed into matrix_out (element k at
// bits [8k +: 8]). Any nonzero high byte sets the sticky hi_err flag.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   start         : one-cycle drain request, ignored unless idle
//   busy, done    : busy in every non-idle state; done pulses after last handshake
//   mem_addr/mem_q: MemoryBlock read port, owned only while busy
//   elem          : element stream (master side)
//   matrix_out    : packed matrix, complete when matrix_valid is high
//   hi_err        : sticky high-byte error, cleared on accepted start
module matrix_result_reader #(
    parameter int unsigned N_ELEM    = coproc_pkg::N_ELEM,
    parameter int unsigned ADDR_W    = coproc_pkg::MEM_ADDR_W,
    parameter int unsigned DATA_W    = coproc_pkg::MEM_DATA_W,
    parameter int unsigned BASE_ADDR = coproc_pkg::RESULT_BASE_ADDR,
    parameter int unsigned READ_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_q,
    matrix_result_reader_if.master elem,
    output logic [8*N_ELEM-1:0]   matrix_out,
    output logic                  matrix_valid,
    output logic                  hi_err
);
    import coproc_pkg::*;

    localparam int unsigned         CntW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CntW-1:0]     CntLast = CntW'(READ_LAT - 1);
    localparam logic [ELEM_IDX_W-1:0] IdxLast = ELEM_IDX_W'(N_ELEM - 1);

    rd_state_t             state_q;
    logic [CntW-1:0]       wait_q;
    logic [ELEM_IDX_W-1:0] idx_q;
    logic                  valid_q;
    logic [ELEM_W-1:0]     data_q;
    logic                  last_q;

    logic [ELEM_W-1:0]     mem_elem;
    logic                  mem_hi_nz;

    assign mem_elem  = mem_q[ELEM_W-1:0];
    assign mem_hi_nz = |mem_q[DATA_W-1:ELEM_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            idx_q        <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            last_q       <= 1'b0;
            done         <= 1'b0;
            mem_addr     <= '0;
            matrix_out   <= '0;
            matrix_valid <= 1'b0;
            hi_err       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mem_addr     <= ADDR_W'(BASE_ADDR);
                        idx_q        <= '0;
                        wait_q       <= '0;
                        matrix_out   <= '0;
                        matrix_valid <= 1'b0;
                        hi_err       <= 1'b0;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    // The capture edge is the READ_LAT-th edge after the address moved.
                    if (wait_q == CntLast) begin
                        data_q                            <= mem_elem;
                        matrix_out[idx_q*ELEM_W +: ELEM_W] <= mem_elem;
                        hi_err                            <= hi_err | mem_hi_nz;
                        last_q                            <= (idx_q == IdxLast);
                        valid_q                           <= 1'b1;
                        state_q                           <= SEND;
                    end else begin
                        wait_q <= wait_q + CntW'(1);
                    end
                end
                SEND: begin
                    if (valid_q && elem.elem_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (idx_q == IdxLast) begin
                            matrix_valid <= 1'b1;
                            done         <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            idx_q    <= idx_q + ELEM_IDX_W'(1);
                            mem_addr <= mem_addr + ADDR_W'(1);
                            wait_q   <= '0;
                            state_q  <= WAIT;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = (state_q != IDLE);
    assign elem.elem_valid = valid_q;
    assign elem.elem_data  = data_q;
    assign elem.elem_index = idx_q;
    assign elem.elem_last  = last_q;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Bench for matrix_result_reader: synchronous-read memory model (one register,
// giving READ_LAT = 2 from address change to capture), scoreboard of expected
// elements pushed at start and popped on each handshake, plus a vector table of
// memory words for sign/high-byte handling.
module tb_matrix_result_reader;
    import coproc_pkg::*;

    localparam int NE   = 25;
    localparam int BASE = 1;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [6:0]            mem_addr;
    logic [15:0]           mem_q;
    logic [8*NE-1:0]       matrix_out;
    logic                  matrix_valid;
    logic                  hi_err;

    matrix_result_reader_if elem_if ();

    matrix_result_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_q        (mem_q),
        .elem         (elem_if),
        .matrix_out   (matrix_out),
        .matrix_valid (matrix_valid),
        .hi_err       (hi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:127];
    always @(posedge clk) mem_q <= mem[mem_addr];

    typedef struct packed {
        logic [15:0] word;
        logic [7:0]  exp_data;
        logic        exp_hi;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] idx;
        logic       last;
    } exp_t;

    vec_t        tbl [8];
    exp_t        sbq [$];
    logic [7:0]  exp_b [NE];
    logic        exp_hi;
    int          n_vec;
    int          n_err;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] all_outs();
        return {30'd0, busy, done, mem_addr, elem_if.elem_valid, elem_if.elem_data,
                elem_if.elem_index, elem_if.elem_last, matrix_valid, hi_err, matrix_out};
    endfunction

    task automatic load_count();
        for (int k = 0; k < NE; k++) begin
            mem[BASE+k] = 16'(k + 1);
            exp_b[k]    = 8'(k + 1);
        end
        exp_hi = 1'b0;
    endtask

    task automatic load_table();
        exp_hi = 1'b0;
        for (int k = 0; k < NE; k++) begin
            mem[BASE+k] = tbl[k%8].word;
            exp_b[k]    = tbl[k%8].exp_data;
            exp_hi      = exp_hi | tbl[k%8].exp_hi;
        end
    endtask

    // One drain: pulse start, consume elements, optionally stall one element,
    // re-pulse start mid-drain, or abort with reset after a given element.
    task automatic drain(input int stall_idx, input int stall_len, input int restart_cyc,
                         input int abort_idx, input int exp_done);
        int          cyc;
        int          done_cyc;
        int          hs_cyc;
        int          stall_cnt;
        logic        rdy;
        logic [20:0] snap;
        logic [8*NE-1:0] mat;
        exp_t        e;
        bit          aborted;

        done_cyc  = -1;
        hs_cyc    = -1;
        stall_cnt = 0;
        aborted   = 0;
        snap      = '0;
        for (int k = 0; k < NE; k++) begin
            sbq.push_back('{exp_b[k], 5'(k), (k == NE - 1)});
            mat[8*k +: 8] = exp_b[k];
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_state", {busy, mem_addr, elem_if.elem_valid, matrix_valid, hi_err},
            {1'b1, 7'(BASE), 1'b0, 1'b0, 1'b0});
        chk("start_matrix_clr", matrix_out, '0);

        cyc = 0;
        while (cyc < 200) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = (cyc == restart_cyc);
            rdy   = 1'b1;
            if (elem_if.elem_valid && int'(elem_if.elem_index) == stall_idx) begin
                if (stall_cnt == 0)
                    snap = {elem_if.elem_valid, elem_if.elem_data, elem_if.elem_index, mem_addr};
                else
                    chk("stall_hold",
                        {elem_if.elem_valid, elem_if.elem_data, elem_if.elem_index, mem_addr}, snap);
                if (stall_cnt < stall_len) begin
                    rdy = 1'b0;
                    stall_cnt++;
                end
            end
            elem_if.elem_ready = rdy;
            if (elem_if.elem_valid && rdy) begin
                hs_cyc = cyc;
                e = (sbq.size() > 0) ? sbq.pop_front() : '1;
                chk("elem", {elem_if.elem_data, elem_if.elem_index, elem_if.elem_last}, e);
                if (int'(elem_if.elem_index) == abort_idx) begin
                    @(posedge clk);
                    #2 reset = 1'b0;
                    #1 chk("async_reset", all_outs(), '0);
                    aborted = 1;
                    break;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        elem_if.elem_ready = 1'b1;

        if (aborted) begin
            sbq.delete();
            repeat (2) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
        end else begin
            chk("done_cycle", done_cyc, exp_done);
            chk("last_hs_cycle", hs_cyc, exp_done - 1);
            chk("matrix_out", matrix_out, mat);
            chk("matrix_valid_hi_err", {matrix_valid, hi_err}, {1'b1, exp_hi});
            chk("sb_empty", sbq.size(), 0);
            @(negedge clk);
            chk("busy_done_fall", {busy, done}, 2'b00);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        tbl[0] = '{16'h00F6, 8'hF6, 1'b0};
        tbl[1] = '{16'h0100, 8'h00, 1'b1};
        tbl[2] = '{16'h007F, 8'h7F, 1'b0};
        tbl[3] = '{16'h0080, 8'h80, 1'b0};
        tbl[4] = '{16'hFFFF, 8'hFF, 1'b1};
        tbl[5] = '{16'h0000, 8'h00, 1'b0};
        tbl[6] = '{16'h00AA, 8'hAA, 1'b0};
        tbl[7] = '{16'h1234, 8'h34, 1'b1};
        for (int a = 0; a < 128; a++) mem[a] = 16'h0;

        start              = 1'b0;
        elem_if.elem_ready = 1'b1;
        reset              = 1'b1;
        #1 reset = 1'b0;
        #1 chk("reset_values", all_outs(), '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Plain drain of 1..25.
        load_count();
        drain(-1, 0, -1, -1, 75);

        // Table of words: sign handling, high-byte error.
        load_table();
        drain(-1, 0, -1, -1, 75);

        // Consumer stalls element 3 for 10 cycles; start clears hi_err first.
        load_count();
        drain(3, 10, -1, -1, 85);

        // Start re-pulsed mid-drain is ignored.
        drain(-1, 0, 20, -1, 75);

        // Reset after element 12, then a full fresh drain.
        drain(-1, 0, -1, 12, 75);
        chk("post_abort_idle", {busy, matrix_valid}, 2'b00);
        drain(-1, 0, -1, -1, 75);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
